ppu_sprite_tile_eval: RTL and testbench

//  Upstream stage of the per-tile VRAM load FSM. For the 8-pixel tile span at (curr_row, curr_col..curr_col+7),

---
 rtl/ppu_sprite_tile_eval_pkg.sv | 28 ++
 rtl/ppu_sprite_match.sv | 35 +++
 rtl/ppu_sprite_tile_eval.sv | 233 +++++++++++++++++++++++
 tb/tb_ppu_sprite_tile_eval.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_sprite_tile_eval_pkg.sv
// Shared definitions for the sprite tile evaluator: OAM byte layout, FSM states, slot record.
// Optional feature macro used by the top: SPRITE_OVERFLOW_EN.
package ppu_sprite_tile_eval_pkg;

  localparam int OAM_Y       = 0;
  localparam int OAM_TILE    = 1;
  localparam int OAM_ATTR    = 2;
  localparam int OAM_X       = 3;
  localparam int SCREEN_ROWS = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       on;
    logic [7:0] tile;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] attr;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/ppu_sprite_match.sv
// Combinational sprite/tile-span overlap test; also usable by sprite-zero-hit logic.
// All arithmetic is 10-bit so X near 255 or col near 0 cannot wrap.
module ppu_sprite_match
  import ppu_sprite_tile_eval_pkg::*;
(
  input  logic [8:0] row_i,
  input  logic [8:0] col_i,
  input  logic       tall_i,
  input  logic [7:0] y_i,
  input  logic [7:0] x_i,
  output logic       hit_o
);

  logic [9:0] row_w;
  logic [9:0] col_w;
  logic [9:0] y_w;
  logic [9:0] x_w;
  logic [9:0] dy_w;
  logic [9:0] h_w;
  logic       row_hit;
  logic       col_hit;

  assign row_w = {1'b0, row_i};
  assign col_w = {1'b0, col_i};
  assign y_w   = {2'b00, y_i};
  assign x_w   = {2'b00, x_i};
  assign dy_w  = row_w - y_w;
  assign h_w   = tall_i ? 10'd16 : 10'd8;

  // Y parked off-screen (>= 240) is the usual "hidden sprite" idiom.
  assign row_hit = (row_w >= y_w) && (dy_w < h_w) && (y_w < 10'(SCREEN_ROWS));
  assign col_hit = ((x_w + 10'd7) >= col_w) && (x_w <= (col_w + 10'd7));
  assign hit_o   = row_hit && col_hit;

endmodule

// File: rtl/ppu_sprite_tile_eval.sv
// Scans OAM in index order and picks the first two sprites overlapping an 8-pixel tile span.
// SPRITE_OVERFLOW_EN: full scan with overflow flag and fixed latency; otherwise early exit, overflow tied 0.
module ppu_sprite_tile_eval
  import ppu_sprite_tile_eval_pkg::*;
#(
  parameter int NUM_SPRITES = 64,
  parameter int OAM_AW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        curr_row,
  input  logic [8:0]        curr_col,
  input  logic              sprite_8x16,
  output logic [OAM_AW-1:0] oam_addr,
  input  logic [7:0]        oam_data_in,
  output logic              sprite_0_on_tile,
  output logic [7:0]        sprite_0_tile_num,
  output logic [7:0]        sprite_0_row,
  output logic [7:0]        sprite_0_col,
  output logic [7:0]        sprite_0_attr,
  output logic              sprite_0_is_oam0,
  output logic              sprite_1_on_tile,
  output logic [7:0]        sprite_1_tile_num,
  output logic [7:0]        sprite_1_row,
  output logic [7:0]        sprite_1_col,
  output logic [7:0]        sprite_1_attr,
  output logic              sprite_overflow,
  output logic              busy,
  output logic              done
);

  localparam logic [OAM_AW-1:0] LAST_ADDR = OAM_AW'(NUM_SPRITES * 4 - 1);

  state_e            state_q, state_d;
  logic [OAM_AW-1:0] addr_q, addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [OAM_AW-1:0] rd_addr_q, rd_addr_d;
  logic [8:0]        row_q, row_d;
  logic [8:0]        col_q, col_d;
  logic              tall_q, tall_d;
  logic [7:0]        y_q, y_d;
  logic [7:0]        tile_q, tile_d;
  logic [7:0]        attr_q, attr_d;
  slot_t             sh0_q, sh0_d;
  slot_t             sh1_q, sh1_d;
  logic              sh0_z_q, sh0_z_d;
  logic              sh_ovf_q, sh_ovf_d;
  slot_t             out0_q, out0_d;
  slot_t             out1_q, out1_d;
  logic              out_z_q, out_z_d;
  logic              out_ovf_q, out_ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hit;
  logic              judge;
  logic [1:0]        byte_sel;
  slot_t             cand;
`ifndef SPRITE_OVERFLOW_EN
  logic              slot1_fill;
`endif

  // X is taken straight off the read bus so the sprite is judged in the same cycle it lands.
  ppu_sprite_match u_match (
    .row_i  (row_q),
    .col_i  (col_q),
    .tall_i (tall_q),
    .y_i    (y_q),
    .x_i    (oam_data_in),
    .hit_o  (hit)
  );

  assign byte_sel = rd_addr_q[1:0];
  assign judge    = rd_vld_q && (byte_sel == 2'(OAM_X)) && hit;
  assign cand     = '{on: 1'b1, tile: tile_q, y: y_q, x: oam_data_in, attr: attr_q};
`ifndef SPRITE_OVERFLOW_EN
  assign slot1_fill = judge && sh0_q.on && !sh1_q.on;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    row_d     = row_q;
    col_d     = col_q;
    tall_d    = tall_q;
    y_d       = y_q;
    tile_d    = tile_q;
    attr_d    = attr_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh0_z_d   = sh0_z_q;
    sh_ovf_d  = sh_ovf_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    out_z_d   = out_z_q;
    out_ovf_d = out_ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (rd_vld_q) begin
      if (byte_sel == 2'(OAM_Y))    y_d    = oam_data_in;
      if (byte_sel == 2'(OAM_TILE)) tile_d = oam_data_in;
      if (byte_sel == 2'(OAM_ATTR)) attr_d = oam_data_in;
    end

    // Index order guarantees the lowest-numbered overlapping sprite lands in slot 0.
    if (judge) begin
      if (!sh0_q.on) begin
        sh0_d   = cand;
        sh0_z_d = (rd_addr_q[OAM_AW-1:2] == '0);
      end else if (!sh1_q.on) begin
        sh1_d = cand;
      end else begin
`ifdef SPRITE_OVERFLOW_EN
        sh_ovf_d = 1'b1;
`endif
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d    = curr_row;
          col_d    = curr_col;
          tall_d   = sprite_8x16;
          sh0_d    = SLOT_EMPTY;
          sh1_d    = SLOT_EMPTY;
          sh0_z_d  = 1'b0;
          sh_ovf_d = 1'b0;
          addr_d   = '0;
          busy_d   = 1'b1;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        rd_vld_d  = 1'b1;
        rd_addr_d = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_FLUSH;
        end else begin
          addr_d = addr_q + OAM_AW'(1);
        end
`ifndef SPRITE_OVERFLOW_EN
        // Both slots full: nothing later in OAM can change the result.
        if (slot1_fill) begin
          rd_vld_d = 1'b0;
          state_d  = ST_FLUSH;
        end
`endif
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out0_d    = sh0_q;
        out1_d    = sh1_q;
        out_z_d   = sh0_z_q;
        out_ovf_d = sh_ovf_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      tall_q    <= 1'b0;
      y_q       <= '0;
      tile_q    <= '0;
      attr_q    <= '0;
      sh0_q     <= SLOT_EMPTY;
      sh1_q     <= SLOT_EMPTY;
      sh0_z_q   <= 1'b0;
      sh_ovf_q  <= 1'b0;
      out0_q    <= SLOT_EMPTY;
      out1_q    <= SLOT_EMPTY;
      out_z_q   <= 1'b0;
      out_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tall_q    <= tall_d;
      y_q       <= y_d;
      tile_q    <= tile_d;
      attr_q    <= attr_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      sh0_z_q   <= sh0_z_d;
      sh_ovf_q  <= sh_ovf_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      out_z_q   <= out_z_d;
      out_ovf_q <= out_ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign oam_addr          = addr_q;
  assign sprite_0_on_tile  = out0_q.on;
  assign sprite_0_tile_num = out0_q.tile;
  assign sprite_0_row      = out0_q.y;
  assign sprite_0_col      = out0_q.x;
  assign sprite_0_attr     = out0_q.attr;
  assign sprite_0_is_oam0  = out_z_q;
  assign sprite_1_on_tile  = out1_q.on;
  assign sprite_1_tile_num = out1_q.tile;
  assign sprite_1_row      = out1_q.y;
  assign sprite_1_col      = out1_q.x;
  assign sprite_1_attr     = out1_q.attr;
  // Without the overflow feature the shadow flag is never set, so this register stays 0.
  assign sprite_overflow   = out_ovf_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_ppu_sprite_tile_eval.sv
// Table-driven bench for ppu_sprite_tile_eval with an OAM memory model and an expected-result queue.
// Expected overflow/latency depend on whether SPRITE_OVERFLOW_EN is defined for the build.
module tb_ppu_sprite_tile_eval;

  typedef struct packed {
    logic       vld;
    logic [5:0] idx;
    logic [7:0] y;
    logic [7:0] t;
    logic [7:0] a;
    logic [7:0] x;
  } spr_t;

  typedef struct packed {
    logic       on0;
    logic [7:0] t0, y0, x0, a0;
    logic       z0;
    logic       on1;
    logic [7:0] t1, y1, x1, a1;
    logic       ovf;
    logic       early;
  } exp_t;

  typedef struct packed {
    spr_t       s0, s1, s2;
    logic [8:0] row;
    logic [8:0] col;
    logic       m16;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] curr_row;
  logic [8:0] curr_col;
  logic       sprite_8x16;
  logic [7:0] oam_addr;
  logic [7:0] oam_data_in;
  logic       s0_on, s0_z, s1_on, ovf, busy, done;
  logic [7:0] s0_t, s0_r, s0_c, s0_a, s1_t, s1_r, s1_c, s1_a;

  logic [7:0] oam [256];
  exp_t       sbq [$];
  vec_t       vecs [11];
  int         checks;
  int         errors;

  ppu_sprite_tile_eval dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .curr_row          (curr_row),
    .curr_col          (curr_col),
    .sprite_8x16       (sprite_8x16),
    .oam_addr          (oam_addr),
    .oam_data_in       (oam_data_in),
    .sprite_0_on_tile  (s0_on),
    .sprite_0_tile_num (s0_t),
    .sprite_0_row      (s0_r),
    .sprite_0_col      (s0_c),
    .sprite_0_attr     (s0_a),
    .sprite_0_is_oam0  (s0_z),
    .sprite_1_on_tile  (s1_on),
    .sprite_1_tile_num (s1_t),
    .sprite_1_row      (s1_r),
    .sprite_1_col      (s1_c),
    .sprite_1_attr     (s1_a),
    .sprite_overflow   (ovf),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OAM read port: data valid one cycle after the address.
  always @(posedge clk) oam_data_in <= oam[oam_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic spr_t sp(input int idx, input int y, input int t, input int a, input int x);
    spr_t r;
    r.vld = 1'b1; r.idx = 6'(idx); r.y = 8'(y); r.t = 8'(t); r.a = 8'(a); r.x = 8'(x);
    return r;
  endfunction

  function automatic exp_t ex(input int on0, input int t0, input int y0, input int x0, input int a0,
                              input int z0, input int on1, input int t1, input int y1, input int x1,
                              input int a1, input int ovf_v, input int early);
    exp_t r;
    r.on0 = 1'(on0); r.t0 = 8'(t0); r.y0 = 8'(y0); r.x0 = 8'(x0); r.a0 = 8'(a0); r.z0 = 1'(z0);
    r.on1 = 1'(on1); r.t1 = 8'(t1); r.y1 = 8'(y1); r.x1 = 8'(x1); r.a1 = 8'(a1);
    r.ovf = 1'(ovf_v); r.early = 1'(early);
    return r;
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = ((i % 4) == 0) ? 8'hFF : 8'h00;
  endtask

  task automatic load_spr(input spr_t s);
    if (s.vld) begin
      oam[int'(s.idx) * 4 + 0] = s.y;
      oam[int'(s.idx) * 4 + 1] = s.t;
      oam[int'(s.idx) * 4 + 2] = s.a;
      oam[int'(s.idx) * 4 + 3] = s.x;
    end
  endtask

  task automatic run_eval(input string nm, input logic [8:0] row, input logic [8:0] col,
                          input logic m16, input exp_t e, input logic disturb);
    int   lat;
    logic got;
    exp_t x;
    @(negedge clk);
    curr_row = row; curr_col = col; sprite_8x16 = m16; start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 400 && !got) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 40) begin
        curr_row = row + 9'd50; curr_col = ~col; sprite_8x16 = ~m16; start = 1'b1;
      end
      if (disturb && lat == 41) start = 1'b0;
      got = done;
    end
    x = sbq.pop_front();
    if (!got) begin
      chk({nm, "_done_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_on0"}, s0_on, x.on0);
    chk({nm, "_tile0"}, s0_t, x.t0);
    chk({nm, "_row0"}, s0_r, x.y0);
    chk({nm, "_col0"}, s0_c, x.x0);
    chk({nm, "_attr0"}, s0_a, x.a0);
    chk({nm, "_oam0"}, s0_z, x.z0);
    chk({nm, "_on1"}, s1_on, x.on1);
    chk({nm, "_tile1"}, s1_t, x.t1);
    chk({nm, "_row1"}, s1_r, x.y1);
    chk({nm, "_col1"}, s1_c, x.x1);
    chk({nm, "_attr1"}, s1_a, x.a1);
`ifdef SPRITE_OVERFLOW_EN
    chk({nm, "_ovf"}, ovf, x.ovf);
    chk({nm, "_latency"}, lat, 258);
`else
    chk({nm, "_ovf"}, ovf, 0);
    if (x.early) chk({nm, "_latency_early"}, int'(lat < 258), 1);
    else         chk({nm, "_latency"}, lat, 258);
`endif
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; curr_row = '0; curr_col = '0; sprite_8x16 = 1'b0;
    clear_oam();

    vecs[0]  = '{s0: '0, s1: '0, s2: '0, row: 9'd10, col: 9'd0, m16: 1'b0,
                 e: ex(0,0,0,0,0,0, 0,0,0,0,0, 0,0)};
    vecs[1]  = '{s0: sp(0,10,8'h05,8'h40,4), s1: '0, s2: '0, row: 9'd12, col: 9'd0, m16: 1'b0,
                 e: ex(1,8'h05,10,4,8'h40,1, 0,0,0,0,0, 0,0)};
    vecs[2]  = '{s0: sp(3,20,8'h33,8'h03,100), s1: sp(7,20,8'h77,8'h07,100), s2: sp(9,20,8'h99,8'h09,100),
                 row: 9'd20, col: 9'd96, m16: 1'b0,
                 e: ex(1,8'h33,20,100,8'h03,0, 1,8'h77,20,100,8'h07, 1,1)};
    vecs[3]  = '{s0: sp(5,50,8'h50,8'h15,40), s1: '0, s2: '0, row: 9'd60, col: 9'd40, m16: 1'b1,
                 e: ex(1,8'h50,50,40,8'h15,0, 0,0,0,0,0, 0,0)};
    vecs[4]  = '{s0: sp(5,50,8'h50,8'h15,40), s1: '0, s2: '0, row: 9'd60, col: 9'd40, m16: 1'b0,
                 e: ex(0,0,0,0,0,0, 0,0,0,0,0, 0,0)};
    vecs[5]  = '{s0: sp(5,50,8'h50,8'h15,40), s1: '0, s2: '0, row: 9'd66, col: 9'd40, m16: 1'b1,
                 e: ex(0,0,0,0,0,0, 0,0,0,0,0, 0,0)};
    vecs[6]  = '{s0: sp(2,100,8'h22,8'h00,0), s1: sp(4,100,8'h44,8'h01,250), s2: '0,
                 row: 9'd100, col: 9'd248, m16: 1'b0,
                 e: ex(1,8'h44,100,250,8'h01,0, 0,0,0,0,0, 0,0)};
    vecs[7]  = '{s0: sp(1,240,8'h11,8'h00,10), s1: sp(6,239,8'h66,8'h02,10), s2: '0,
                 row: 9'd239, col: 9'd8, m16: 1'b0,
                 e: ex(1,8'h66,239,10,8'h02,0, 0,0,0,0,0, 0,0)};
    vecs[8]  = '{s0: sp(10,30,8'hAA,8'h80,8), s1: '0, s2: '0, row: 9'd37, col: 9'd1, m16: 1'b0,
                 e: ex(1,8'hAA,30,8,8'h80,0, 0,0,0,0,0, 0,0)};
    vecs[9]  = '{s0: sp(10,30,8'hAA,8'h80,8), s1: '0, s2: '0, row: 9'd38, col: 9'd0, m16: 1'b0,
                 e: ex(0,0,0,0,0,0, 0,0,0,0,0, 0,0)};
    vecs[10] = '{s0: sp(0,5,8'h01,8'h11,0), s1: sp(63,5,8'h3F,8'h22,0), s2: '0,
                 row: 9'd5, col: 9'd0, m16: 1'b0,
                 e: ex(1,8'h01,5,0,8'h11,1, 1,8'h3F,5,0,8'h22, 0,0)};

    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_on0", s0_on, 0);
    chk("reset_on1", s1_on, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_addr", oam_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 11; v++) begin
      clear_oam();
      load_spr(vecs[v].s0);
      load_spr(vecs[v].s1);
      load_spr(vecs[v].s2);
      run_eval($sformatf("vec%0d", v), vecs[v].row, vecs[v].col, vecs[v].m16, vecs[v].e, 1'b0);
    end

    // Inputs wiggled and a stray start mid-scan must not affect the latched evaluation.
    clear_oam();
    load_spr(vecs[1].s0);
    run_eval("latched", vecs[1].row, vecs[1].col, vecs[1].m16, vecs[1].e, 1'b1);

    // Abort mid-scan with reset, then a fresh evaluation.
    clear_oam();
    load_spr(vecs[2].s0);
    load_spr(vecs[2].s1);
    load_spr(vecs[2].s2);
    @(negedge clk);
    curr_row = vecs[2].row; curr_col = vecs[2].col; sprite_8x16 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midscan_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_on0", s0_on, 0);
    chk("abort_tile0", s0_t, 0);
    chk("abort_oam0", s0_z, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", oam_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    run_eval("after_abort", vecs[2].row, vecs[2].col, 1'b0, vecs[2].e, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
